// File: rtl/inst_fetch_pkg.sv
// Shared widths, PC step and fetch-state encoding for the instruction fetch block.
package inst_fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        FULL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Bundle of the ROM port, redirect request and decode-side valid/ready handshake.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;

    // master is the fetch unit; slave is the ROM/decode/branch side
    modport master (
        output rom_addr,
        input  rom_dout,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    modport slave (
        input  rom_addr,
        output rom_dout,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );

endinterface

// File: rtl/inst_fetch_buf.sv
// Small FIFO of {pc, data} fetched words; flush empties it and drops a same-cycle push.
module inst_fetch_buf
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic [DATA_W-1:0]        push_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [ADDR_W-1:0]        head_pc,
    output logic [DATA_W-1:0]        head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // Storage is cleared on reset so the head reads as zero until the first word lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= push_pc;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_pc   = pc_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch initiator: streams word addresses to a 1-cycle ROM and hands words to decode.
// Define INST_FETCH_HALT_AT_END_EN to stop fetching (DONE) after address 8'hFC instead of wrapping.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
    parameter int                BUF_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    inst_fetch_if.master   bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
`ifdef INST_FETCH_HALT_AT_END_EN
    localparam logic [ADDR_W-1:0] LAST_PC = {{(ADDR_W-2){1'b1}}, 2'b00};
`endif

    state_t            state;
    logic              in_flight;
    logic [ADDR_W-1:0] issued_pc;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W:0]    fill;
    logic              pop;
    logic              push;
    logic              space;
    logic              issue;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_data;

    // Credit check counts the word still coming back from the ROM and frees the slot popped this cycle
    assign pop   = bus.instr_valid && bus.instr_ready;
    assign push  = in_flight && !bus.redirect_valid;
    assign fill  = {1'b0, occupancy} + (CNT_W+1)'(in_flight) - (CNT_W+1)'(pop);
    assign space = fill < (CNT_W+1)'(BUF_DEPTH);
    assign issue = (state == RUN) && space && !bus.redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            bus.rom_addr <= RESET_PC;
            issued_pc    <= RESET_PC;
            in_flight    <= 1'b0;
        end else if (bus.redirect_valid) begin
            state        <= RUN;
            bus.rom_addr <= bus.redirect_pc & ~ADDR_W'(3);
            in_flight    <= 1'b0;
        end else begin
            in_flight <= issue;
            if (issue) begin
                bus.rom_addr <= bus.rom_addr + ADDR_W'(PC_STEP);
                issued_pc    <= bus.rom_addr;
            end
            case (state)
                RUN: begin
                    if (!space) begin
                        state <= FULL;
                    end
`ifdef INST_FETCH_HALT_AT_END_EN
                    else if (bus.rom_addr == LAST_PC) begin
                        state <= DONE;
                    end
`endif
                end
                FULL: begin
                    if (space) begin
                        state <= RUN;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    inst_fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .push_pc   (issued_pc),
        .push_data (bus.rom_dout),
        .occupancy (occupancy),
        .head_pc   (head_pc),
        .head_data (head_data)
    );

    assign bus.instr_valid = (occupancy != '0);
    assign bus.instr_pc    = head_pc;
    assign bus.instr_data  = head_data;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed scenarios push expected PCs, a negedge monitor checks transfers.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;

    inst_fetch_if bus ();

    inst_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        return {a ^ 8'h5A, 8'h3C, ~a, a};
    endfunction

    // Synchronous ROM model with one cycle of read latency
    always @(posedge clk) begin
        bus.rom_dout <= rom_word(bus.rom_addr);
    end

    logic [7:0]  exp_q [$];
    int          compared   = 0;
    int          mismatched = 0;
    int          xfer_cnt   = 0;
    logic        prev_hold  = 1'b0;
    logic [7:0]  prev_pc    = '0;
    logic [31:0] prev_data  = '0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted word and checks stalled outputs stay put
    always @(negedge clk) begin
        logic [7:0] exp_pc;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check_output("hold_valid", 32'(bus.instr_valid), 32'd1);
                check_output("hold_pc", 32'(bus.instr_pc), 32'(prev_pc));
                check_output("hold_data", bus.instr_data, prev_data);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_word: got pc %h, expected none", bus.instr_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    check_output("xfer_pc", 32'(bus.instr_pc), 32'(exp_pc));
                    check_output("xfer_data", bus.instr_data, rom_word(exp_pc));
                end
            end
            prev_hold = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
            prev_pc   = bus.instr_pc;
            prev_data = bus.instr_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [7:0] start, input int n);
        logic [7:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pc);
            pc = pc + 8'd4;
        end
    endtask

    // Holds ready high until the monitor has seen target transfers, then drops it
    task automatic wait_xfers(input int target);
        int waited;
        waited = 0;
        bus.instr_ready = 1'b1;
        while (xfer_cnt < target && waited < 200) begin
            step();
            waited++;
        end
        bus.instr_ready = 1'b0;
        if (xfer_cnt < target) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL xfer_timeout: got %0d transfers, expected %0d", xfer_cnt, target);
        end
    endtask

    task automatic run_from_reset();
        int target;
        exp_q.delete();
        push_seq(8'h00, 8);
        target = xfer_cnt + 8;
        step();
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        check_output("lat_c0_valid", 32'(bus.instr_valid), 32'd0);
        check_output("lat_c0_addr", 32'(bus.rom_addr), 32'h00);
        @(negedge clk);
        check_output("lat_c1_valid", 32'(bus.instr_valid), 32'd0);
        check_output("lat_c1_addr", 32'(bus.rom_addr), 32'h04);
        @(negedge clk);
        check_output("lat_c2_valid", 32'(bus.instr_valid), 32'd1);
        check_output("lat_c2_pc", 32'(bus.instr_pc), 32'h00);
        wait_xfers(target);
    endtask

    task automatic apply_stimulus();
        int target;

        rst                = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_addr", 32'(bus.rom_addr), 32'h00);
        check_output("rst_valid", 32'(bus.instr_valid), 32'd0);
        check_output("rst_pc", 32'(bus.instr_pc), 32'h00);
        check_output("rst_data", bus.instr_data, 32'h0);

        $display("[TB] stream from reset");
        run_from_reset();

        $display("[TB] stall for 5 cycles");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("stall_addr", 32'(bus.rom_addr), 32'h28);
            check_output("stall_pc", 32'(bus.instr_pc), 32'h20);
        end
        step();
        push_seq(8'h20, 6);
        wait_xfers(xfer_cnt + 6);

        $display("[TB] redirect to 8'h43 with full buffer");
        repeat (4) step();
        @(negedge clk);
        check_output("pre_redir_valid", 32'(bus.instr_valid), 32'd1);
        check_output("pre_redir_pc", 32'(bus.instr_pc), 32'h38);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h43;
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check_output("redir_valid_r1", 32'(bus.instr_valid), 32'd0);
        check_output("redir_addr_r1", 32'(bus.rom_addr), 32'h40);
        @(negedge clk);
        check_output("redir_valid_r2", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        check_output("redir_valid_r3", 32'(bus.instr_valid), 32'd1);
        check_output("redir_pc_r3", 32'(bus.instr_pc), 32'h40);
        step();
        push_seq(8'h40, 4);
        wait_xfers(xfer_cnt + 4);

        $display("[TB] redirect coincident with pop");
        repeat (4) step();
        @(negedge clk);
        check_output("pre_pop_pc", 32'(bus.instr_pc), 32'h50);
        step();
        target = xfer_cnt + 4;
        exp_q.push_back(8'h50);
        push_seq(8'h80, 3);
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h80;
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check_output("pop_redir_valid", 32'(bus.instr_valid), 32'd0);
        check_output("pop_redir_addr", 32'(bus.rom_addr), 32'h80);
        step();
        wait_xfers(target);

        $display("[TB] redirect to 8'hF8 across the top of the address space");
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'hF8;
        step();
        bus.redirect_valid = 1'b0;
`ifdef INST_FETCH_HALT_AT_END_EN
        push_seq(8'hF8, 2);
        wait_xfers(xfer_cnt + 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("done_valid", 32'(bus.instr_valid), 32'd0);
            check_output("done_addr", 32'(bus.rom_addr), 32'h00);
        end
        step();
`else
        push_seq(8'hF8, 4);
        wait_xfers(xfer_cnt + 4);
`endif

        $display("[TB] reset asserted mid-stream");
        push_seq(8'h08, 6);
        bus.instr_ready = 1'b1;
        repeat (3) step();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_output("async_rst_valid", 32'(bus.instr_valid), 32'd0);
        check_output("async_rst_addr", 32'(bus.rom_addr), 32'h00);
        check_output("async_rst_pc", 32'(bus.instr_pc), 32'h00);
        bus.instr_ready = 1'b0;
        run_from_reset();

        repeat (3) step();
        check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        apply_stimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch initiator for the 8-bit-addressed, 32-bit-wide synchronous program ROM (one-cycle read latency).
- Generates word-aligned byte addresses (step 4) and captures returned words.
- Presents each word with its PC to the decode stage over a valid/ready handshake; supports branch redirect.
- Sits between the program ROM and the decode/execute stages of the lab CPU datapath.

Parameters:
- ADDR_W, 8, ROM byte-address width.
- DATA_W, 32, instruction word width.
- RESET_PC, 8'h00, first fetch address after reset (bits [1:0] must be 0).
- BUF_DEPTH, 2, fetched-word buffer entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_addr  out  ADDR_W  byte address to ROM; registered.
- rom_dout  in  DATA_W  ROM read data, valid the cycle after rom_addr was issued.
- redirect_valid  in  1  branch/jump request, single cycle.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored (forced 0).
- instr_valid  out  1  instr_data/instr_pc hold a fetched word.
- instr_ready  in  1  decode accepts word; transfer when valid && ready.
- instr_data  out  DATA_W  fetched instruction.
- instr_pc  out  ADDR_W  byte address of instr_data.

Behaviour:
- Reset (async, immediate): rom_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, buffer empty, in_flight=0, state RUN.
- Issue: cycle k with issue=1 means the ROM samples rom_addr at the end of k; rom_dout is valid in k+1 and written (with PC tag) into the buffer at the end of k+1; instr_valid rises in k+2 at the earliest. First word appears 2 cycles after rst deasserts.
- issue = (state==RUN) && (occupancy + in_flight - pop < BUF_DEPTH), where pop = instr_valid && instr_ready. This allows one word per cycle sustained with ready held high.
- On issue: pc <= pc + 4, modulo 256 (8'hFC -> 8'h00), and in_flight <= 1. Without issue: rom_addr holds and in_flight <= 0.
- States:
  - RUN -> FULL when the issue condition fails.
  - FULL -> RUN when space frees.
  - Any state -> RUN on redirect.
  - DONE exists only with the optional feature.
- Buffer is FIFO-ordered; head drives instr_data/instr_pc. Outputs are stable while valid && !ready.
- No word is lost or duplicated under any ready pattern.
- Redirect (highest priority):
  - pc/rom_addr <= {redirect_pc[7:2],2'b00}.
  - Buffer and in_flight are cleared.
  - No issue that cycle.
  - ROM data returning next cycle is discarded.
  - instr_valid is 0 the next cycle; the first redirected word is valid 2 cycles after rom_addr updates.
  - Redirect coincident with a pop: the pop counts as completed, then the flush applies.
- Reset mid-operation: all state is cleared immediately and fetch restarts at RESET_PC.

Optional Feature:
- Macro: INST_FETCH_HALT_AT_END_EN.
- Defined: after issuing 8'hFC, the block enters DONE. No further issues; the buffered words drain normally. Only redirect or reset leaves DONE.
- Undefined: the PC wraps 8'hFC -> 8'h00 and fetching continues. The DONE state is not synthesized.

Decomposition:
- Package inst_fetch_pkg: ADDR_W, DATA_W, PC_STEP=4, and the state encoding (RUN, FULL, DONE).
- Sub-module inst_fetch_buf: BUF_DEPTH-entry synchronous FIFO of {pc, data}. It has push, pop, flush, occupancy, head outputs and async reset.

Test Plan:
- Reset release, instr_ready=1 -> instr_pc 00,04,08,...,1C on consecutive cycles starting 2 cycles after release; instr_data equals ROM words.
- instr_ready=0 for 5 cycles mid-stream -> occupancy reaches 2, rom_addr freezes, instr_pc/instr_data stable; on release, words resume in order with no gaps or duplicates.
- redirect_valid with redirect_pc=8'h43 while 2 words are buffered -> instr_valid=0 next cycle; next valid word has instr_pc=8'h40 and no stale word appears.
- redirect_pc=8'hF8, ready=1 -> macro undefined: F8,FC,00,04; macro defined: F8,FC, then instr_valid stays 0 and rom_addr holds until redirect.
- rst asserted between clock edges during streaming -> instr_valid=0 and rom_addr=00 without waiting for an edge; restart matches the first scenario.
- Redirect in the same cycle as an accepted pop -> popped word counted once; next valid word is at redirect_pc.
